// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory arbiter.
//   state_e : arbiter FSM states (IDLE, ISSUE, RESP)
//   port_e  : requester identifiers (PORT_FETCH = 0, PORT_DATA = 1)
//   DATA_W_DEF / ADDR_W_DEF : default data and address widths
//   CNT_W   : width of the saturating conflict counter
package mem_arb_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned CNT_W      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    typedef enum logic {
        PORT_FETCH = 1'b0,
        PORT_DATA  = 1'b1
    } port_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and a single-port
// synchronous memory.
//   fetch port : f_req, f_addr -> arbiter; f_rdata, f_ack <- arbiter
//   data port  : d_req, d_we, d_addr, d_wdata -> arbiter; d_rdata, d_ack <- arbiter
//   memory     : m_en, m_we, m_addr, m_wdata <- arbiter; m_rdata -> arbiter
// Modport slave is the arbiter view; master is the requester/memory view.
interface mem_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
);

    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic [DATA_W-1:0] f_rdata;
    logic              f_ack;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [DATA_W-1:0] d_rdata;
    logic              d_ack;

    logic              m_en;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [DATA_W-1:0] m_rdata;

    modport slave (
        input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        output f_rdata, f_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata
    );

    modport master (
        output f_req, f_addr, d_req, d_we, d_addr, d_wdata, m_rdata,
        input  f_rdata, f_ack, d_rdata, d_ack, m_en, m_we, m_addr, m_wdata
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick, purely combinational.
//   req[1:0]   : eligible requesters, indexed by port_e
//   last_grant : port granted most recently
//   grant      : winning port (don't-care when req == 0)
// A lone requester always wins; on a tie the port not granted last wins.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  port_e      last_grant,
    output port_e      grant
);

    always_comb begin
        grant = PORT_FETCH;
        case (req)
            2'b01:   grant = PORT_FETCH;
            2'b10:   grant = PORT_DATA;
            2'b11:   grant = (last_grant == PORT_DATA) ? PORT_FETCH : PORT_DATA;
            default: grant = PORT_FETCH;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory with
// a 1-cycle synchronous read. Each access runs IDLE -> ISSUE -> RESP and
// returns a registered one-cycle ack in the cycle after RESP.
//   clk          : clock, rising edge
//   Reset_n      : asynchronous active-low reset
//   bus          : mem_arbiter_if.slave (fetch, data and memory signals)
//   conflict_cnt : saturating count of IDLE cycles with both ports eligible
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
)(
    input  logic             clk,
    input  logic             Reset_n,
    mem_arbiter_if.slave     bus,
    output logic [CNT_W-1:0] conflict_cnt
);

    state_e            state_q, state_d;
    port_e             grant_q, last_grant_q, win;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              f_ack_q, d_ack_q;
    logic [DATA_W-1:0] f_rdata_q, d_rdata_q;
    logic [CNT_W-1:0]  conflict_q;
    logic              f_elig, d_elig, take;

    // A port whose ack is showing this cycle still has req high; masking it
    // here stops that req from starting a second access.
    assign f_elig = bus.f_req & ~f_ack_q;
    assign d_elig = bus.d_req & ~d_ack_q;
    assign take   = (state_q == IDLE) && (f_elig || d_elig);

    rr_arbiter2 u_rr (
        .req        ({d_elig, f_elig}),
        .last_grant (last_grant_q),
        .grant      (win)
    );

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        bus.m_en    = 1'b0;
        bus.m_we    = 1'b0;
        bus.m_addr  = '0;
        bus.m_wdata = '0;
        case (state_q)
            IDLE: begin
                if (take) begin
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                bus.m_en    = 1'b1;
                bus.m_we    = we_q;
                bus.m_addr  = addr_q;
                bus.m_wdata = wdata_q;
                state_d     = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The winner's request fields are captured at grant time so that an
    // early req drop cannot corrupt the access already committed to.
    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            grant_q      <= PORT_FETCH;
            last_grant_q <= PORT_DATA;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (take) begin
            grant_q      <= win;
            last_grant_q <= win;
            if (win == PORT_DATA) begin
                we_q    <= bus.d_we;
                addr_q  <= bus.d_addr;
                wdata_q <= bus.d_wdata;
            end else begin
                we_q    <= 1'b0;
                addr_q  <= bus.f_addr;
                wdata_q <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            f_ack_q   <= 1'b0;
            d_ack_q   <= 1'b0;
            f_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            f_ack_q <= (state_q == RESP) && (grant_q == PORT_FETCH);
            d_ack_q <= (state_q == RESP) && (grant_q == PORT_DATA);
            if ((state_q == RESP) && (grant_q == PORT_FETCH)) begin
                f_rdata_q <= bus.m_rdata;
            end
            if ((state_q == RESP) && (grant_q == PORT_DATA) && !we_q) begin
                d_rdata_q <= bus.m_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            conflict_q <= '0;
        end else if ((state_q == IDLE) && f_elig && d_elig && (conflict_q != '1)) begin
            conflict_q <= conflict_q + 1'b1;
        end
    end

    assign bus.f_ack     = f_ack_q;
    assign bus.d_ack     = d_ack_q;
    assign bus.f_rdata   = f_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign conflict_cnt  = conflict_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed transactions push expected
// acks and memory issues into queues; a negedge monitor pops and compares.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    typedef struct {
        logic [15:0] rdata;
        int unsigned cyc;
    } ack_t;

    typedef struct {
        int unsigned cyc;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
    } iss_t;

    logic        clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic [15:0] conflict_cnt;
    int unsigned cyc = 0;
    int unsigned checks = 0;
    int unsigned fails = 0;
    int unsigned ack_total = 0;
    logic        prev_m_en = 1'b0;

    ack_t fq[$];
    ack_t dq[$];
    iss_t iq[$];

    logic [15:0] mem [0:65535];

    mem_arbiter_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    mem_arbiter #(.DATA_W(16), .ADDR_W(16)) dut (
        .clk          (clk),
        .Reset_n      (Reset_n),
        .bus          (bus),
        .conflict_cnt (conflict_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Single-port memory with 1-cycle synchronous read
    always @(posedge clk) begin
        if (bus.m_en) begin
            if (bus.m_we) mem[bus.m_addr] <= bus.m_wdata;
            else          bus.m_rdata <= mem[bus.m_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got=%h expected=%h (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor / scoreboard
    initial begin : monitor
        ack_t a;
        int   idx;
        forever begin
            @(negedge clk);
            if (bus.f_ack) begin
                ack_total++;
                if (fq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL f_ack_unexpected: got=ack expected=none (cyc %0d)", cyc);
                end else begin
                    a = fq.pop_front();
                    chk("f_rdata", {16'h0, bus.f_rdata}, {16'h0, a.rdata});
                    chk("f_ack_cycle", cyc, a.cyc);
                end
            end
            if (bus.d_ack) begin
                ack_total++;
                if (dq.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL d_ack_unexpected: got=ack expected=none (cyc %0d)", cyc);
                end else begin
                    a = dq.pop_front();
                    chk("d_rdata", {16'h0, bus.d_rdata}, {16'h0, a.rdata});
                    chk("d_ack_cycle", cyc, a.cyc);
                end
            end
            if (bus.m_en) begin
                chk("m_en_back_to_back", {31'h0, prev_m_en}, 32'h0);
                idx = -1;
                foreach (iq[k]) if (idx < 0 && iq[k].cyc == cyc) idx = k;
                if (idx < 0) begin
                    checks++; fails++;
                    $display("FAIL m_issue_unexpected: got addr=%h we=%b expected=none (cyc %0d)",
                             bus.m_addr, bus.m_we, cyc);
                end else begin
                    chk("m_addr", {16'h0, bus.m_addr}, {16'h0, iq[idx].addr});
                    chk("m_we", {31'h0, bus.m_we}, {31'h0, iq[idx].we});
                    if (iq[idx].we) chk("m_wdata", {16'h0, bus.m_wdata}, {16'h0, iq[idx].wdata});
                    iq.delete(idx);
                end
            end
            prev_m_en = bus.m_en;
        end
    end

    // lat = ack cycle relative to the cycle the request is raised
    task automatic fetch_txn(input logic [15:0] addr, input logic [15:0] exp, input int unsigned lat);
        int unsigned start;
        bit          seen;
        ack_t        a;
        iss_t        s;
        start = cyc;
        bus.f_req  = 1'b1;
        bus.f_addr = addr;
        s.cyc = start + lat - 2; s.we = 1'b0; s.addr = addr; s.wdata = 16'h0;
        iq.push_back(s);
        a.rdata = exp; a.cyc = start + lat;
        fq.push_back(a);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk); #1;
            seen = bus.f_ack;
        end
        if (!seen) begin
            checks++; fails++;
            $display("FAIL f_ack_timeout: got=no ack expected=ack for addr %h", addr);
        end
        @(posedge clk); #1;
        bus.f_req = 1'b0;
    endtask

    task automatic data_txn(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                            input logic [15:0] exp, input int unsigned lat);
        int unsigned start;
        bit          seen;
        ack_t        a;
        iss_t        s;
        start = cyc;
        bus.d_req   = 1'b1;
        bus.d_we    = we;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        s.cyc = start + lat - 2; s.we = we; s.addr = addr; s.wdata = wdata;
        iq.push_back(s);
        a.rdata = exp; a.cyc = start + lat;
        dq.push_back(a);
        seen = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk); #1;
            seen = bus.d_ack;
        end
        if (!seen) begin
            checks++; fails++;
            $display("FAIL d_ack_timeout: got=no ack expected=ack for addr %h", addr);
        end
        @(posedge clk); #1;
        bus.d_req = 1'b0;
    endtask

    initial begin : stim
        int unsigned acks_before;
        iss_t        s;

        for (int i = 0; i < 65536; i++) mem[i] = 16'h0;
        mem[16'h0010] = 16'hA5C3;
        for (int i = 0; i < 8; i++) mem[16'h0100 + i] = 16'hC000 + 16'(i);
        bus.f_req = 1'b0; bus.f_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
        bus.m_rdata = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_f_ack", {31'h0, bus.f_ack}, 32'h0);
        chk("rst_d_ack", {31'h0, bus.d_ack}, 32'h0);
        chk("rst_f_rdata", {16'h0, bus.f_rdata}, 32'h0);
        chk("rst_d_rdata", {16'h0, bus.d_rdata}, 32'h0);
        chk("rst_m_en", {31'h0, bus.m_en}, 32'h0);
        chk("rst_m_we", {31'h0, bus.m_we}, 32'h0);
        chk("rst_conflict_cnt", {16'h0, conflict_cnt}, 32'h0);
        Reset_n = 1'b1;
        @(posedge clk); #1;

        // Single read, write / read-back, write keeps d_rdata
        fetch_txn(16'h0010, 16'hA5C3, 3);
        data_txn(1'b1, 16'h0200, 16'h1234, 16'h0000, 3);
        data_txn(1'b0, 16'h0200, 16'h0000, 16'h1234, 3);
        data_txn(1'b1, 16'h0300, 16'h5555, 16'h1234, 3);
        data_txn(1'b0, 16'h0300, 16'h0000, 16'h5555, 3);
        chk("cnt_no_conflict", {16'h0, conflict_cnt}, 32'h0);

        // Reset while ISSUE is driving the memory
        bus.f_req = 1'b1; bus.f_addr = 16'h0040;
        s.cyc = cyc + 1; s.we = 1'b0; s.addr = 16'h0040; s.wdata = 16'h0;
        iq.push_back(s);
        @(posedge clk); @(negedge clk); #1;
        chk("issue_before_rst_m_en", {31'h0, bus.m_en}, 32'h1);
        acks_before = ack_total;
        Reset_n = 1'b0;
        #1;
        chk("rst_mid_m_en", {31'h0, bus.m_en}, 32'h0);
        chk("rst_mid_m_we", {31'h0, bus.m_we}, 32'h0);
        chk("rst_mid_f_ack", {31'h0, bus.f_ack}, 32'h0);
        chk("rst_mid_d_ack", {31'h0, bus.d_ack}, 32'h0);
        bus.f_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        Reset_n = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        chk("no_ack_after_abandon", ack_total, acks_before);
        chk("rst_mid_d_rdata", {16'h0, bus.d_rdata}, 32'h0);

        // Conflict after reset: fetch first, data 3 cycles later
        fork
            fetch_txn(16'h0010, 16'hA5C3, 3);
            data_txn(1'b0, 16'h0200, 16'h0000, 16'h1234, 6);
        join
        chk("cnt_after_first_conflict", {16'h0, conflict_cnt}, 32'h1);

        // After a lone fetch grant, the next conflict goes to data
        fetch_txn(16'h0010, 16'hA5C3, 3);
        fork
            fetch_txn(16'h0200, 16'h1234, 6);
            data_txn(1'b0, 16'h0010, 16'h0000, 16'hA5C3, 3);
        join
        chk("cnt_after_rr_conflict", {16'h0, conflict_cnt}, 32'h2);

        // Continuous contention, 8 accesses alternating D, F, D, F ...
        fork
            begin
                for (int i = 0; i < 4; i++)
                    fetch_txn(16'h0100 + 16'(2*i), 16'hC000 + 16'(2*i), (i == 0) ? 6 : 5);
            end
            begin
                for (int i = 0; i < 4; i++)
                    data_txn(1'b0, 16'h0101 + 16'(2*i), 16'h0000, 16'hC001 + 16'(2*i), (i == 0) ? 3 : 5);
            end
        join
        chk("cnt_after_contention", {16'h0, conflict_cnt}, 32'h3);

        // Saturation
        force dut.conflict_q = 16'hFFFE;
        @(posedge clk); #1;
        release dut.conflict_q;
        @(posedge clk); #1;
        chk("cnt_preload", {16'h0, conflict_cnt}, 32'hFFFE);
        for (int i = 0; i < 3; i++) begin
            fork
                fetch_txn(16'h0010, 16'hA5C3, 6);
                data_txn(1'b0, 16'h0200, 16'h0000, 16'h1234, 3);
            join
            chk("cnt_saturated", {16'h0, conflict_cnt}, 32'hFFFF);
        end

        repeat (6) @(posedge clk);
        #1;
        chk("fq_drained", fq.size(), 32'h0);
        chk("dq_drained", dq.size(), 32'h0);
        chk("iq_drained", iq.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        fails++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
